// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with per-key debounce and a 4-entry key-code FIFO.
// Optional auto-repeat while a key is held is enabled with `define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV      = 1000,
    parameter int DEB_CYCLES    = 500,
    parameter int REPEAT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_rd,
    output logic       overflow
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DEB, HOLD, REL_DEB} state_e;

    state_e           state_q, state_d;
    logic [3:0]       sync1_q, rs_q;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]       fifo_q [4];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             overflow_q, overflow_d;

    logic       row_low, deb_done, push, pop, full, wr_en;
    logic [1:0] first_low;
    logic [3:0] push_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_fire;
`endif

    // NOTE: sequential state uses <= so every flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 4'hF;
            rs_q       <= 4'hF;
            state_q    <= SCAN;
            col_idx_q  <= '0;
            row_idx_q  <= '0;
            div_cnt_q  <= '0;
            deb_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= row_in;
            rs_q       <= sync1_q;
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            row_idx_q  <= row_idx_d;
            div_cnt_q  <= div_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: FIFO storage has no reset; key_code is masked by key_valid so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_q[wr_ptr_q] <= push_code;
        end
    end

    // Lowest-index low row wins when several rows are active.
    always_comb begin
        first_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs_q[i]) begin
                first_low = 2'(i);
            end
        end
    end

    assign row_low  = !rs_q[row_idx_q];
    assign deb_done = (deb_cnt_q == DEB_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        div_cnt_d = div_cnt_q;
        deb_cnt_d = deb_cnt_q;
        case (state_q)
            SCAN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (rs_q == 4'hF) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = first_low;
                        deb_cnt_d = '0;
                        state_d   = PRESS_DEB;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            PRESS_DEB: begin
                if (!row_low) begin
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    deb_cnt_d = '0;
                end else if (deb_done) begin
                    state_d   = HOLD;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!row_low) begin
                    state_d   = REL_DEB;
                    deb_cnt_d = '0;
                end
            end
            REL_DEB: begin
                if (row_low) begin
                    state_d   = HOLD;
                    deb_cnt_d = '0;
                end else if (deb_done) begin
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Repeat interval restarts on every push and clears whenever the key is not held.
    always_comb begin
        rep_cnt_d = '0;
        rep_fire  = 1'b0;
        if (state_q == HOLD && row_low) begin
            if (rep_cnt_q == REP_LAST) begin
                rep_fire = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        col_out   = ~(4'b0001 << col_idx_q);
        push_code = {col_idx_q, row_idx_q};
        push      = (state_q == PRESS_DEB) && row_low && deb_done;
`ifdef KEYPAD_REPEAT_EN
        push      = push || rep_fire;
`endif
    end

    // A pop frees the head slot in the same edge, so a push into a full FIFO still lands.
    always_comb begin
        full       = (count_q == 3'd4);
        pop        = key_rd && (count_q != 3'd0);
        wr_en      = push && (!full || pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 3'd1;
        end else if (!wr_en && pop) begin
            count_d = count_q - 3'd1;
        end
        overflow_d = overflow_q || (push && full && !pop);
    end

    assign key_valid = (count_q != 3'd0);
    assign key_code  = key_valid ? fifo_q[rd_ptr_q] : 4'h0;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a keypad model drives rows from the columns,
// expected codes go into a queue and a monitor compares every popped key_code.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV      = 4;
    localparam int DEB_CYCLES    = 3;
    localparam int REPEAT_CYCLES = 20;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXTRA_REPEATS = 3;
`else
    localparam int EXTRA_REPEATS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_rd;
    logic       overflow;

    logic [15:0] press_mask;
    logic        glitch_en;
    logic [3:0]  glitch_rows;
    logic [3:0]  keypad_rows;

    int         chk_cnt = 0;
    int         err_cnt = 0;
    logic [3:0] exp_q[$];
    logic       exp_ovf;
    logic [3:0] mon_exp;

    keypad_scan_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .DEB_CYCLES   (DEB_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_rd   (key_rd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low only while its column is driven low.
    always_comb begin
        keypad_rows = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (press_mask[c*4+r] && !col_out[c]) begin
                    keypad_rows[r] = 1'b0;
                end
            end
        end
        row_in = glitch_en ? glitch_rows : keypad_rows;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared with the oldest expected code.
    always @(negedge clk) begin
        if (!rst && key_valid && key_rd) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                err_cnt++;
                $display("FAIL pop_unexpected: got code %0h expected no entry", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop_code", 32'(key_code), 32'(mon_exp));
            end
        end
    end

    task automatic wait_col_start(input int c);
        logic [3:0] target;
        int n;
        target = ~(4'b0001 << c);
        n = 0;
        @(negedge clk);
        while (col_out == target && n < 80) begin @(negedge clk); n++; end
        while (col_out != target && n < 80) begin @(negedge clk); n++; end
        check("col_reach", 32'(col_out), 32'(target));
    endtask

    task automatic press_hold(input int c, input int r, input int hold);
        wait_col_start(c);
        press_mask[c*4+r] = 1'b1;
        repeat (hold) @(negedge clk);
        press_mask = '0;
    endtask

    task automatic pop_one();
        logic [3:0] dropped;
        @(negedge clk);
        if (!key_valid) begin
            check("pop_avail", 32'(key_valid), 32'd1);
            if (exp_q.size() > 0) dropped = exp_q.pop_front();
        end else begin
            @(posedge clk);
            #1 key_rd = 1'b1;
            @(posedge clk);
            #1 key_rd = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 8) begin
            pop_one();
            guard++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!key_valid && n < 80) begin @(negedge clk); n++; end
        check(name, 32'(key_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] prev_col;
        logic [3:0] code;
        int run, n, start, c, r;
        bit seen;

        rst         = 1'b1;
        key_rd      = 1'b0;
        press_mask  = '0;
        glitch_en   = 1'b0;
        glitch_rows = 4'hF;
        exp_ovf     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_col_out", 32'(col_out), 32'hE);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Idle scan: one-hot-low rotation, SCAN_DIV cycles per column.
        prev_col = col_out;
        run = 1;
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (col_out == prev_col) begin
                run++;
            end else begin
                check("scan_next_col", 32'(col_out), 32'({prev_col[2:0], prev_col[3]}));
                if (seen) check("scan_dwell", 32'(run), 32'(SCAN_DIV));
                seen = 1'b1;
                run = 1;
                prev_col = col_out;
            end
        end
        check("idle_key_valid", 32'(key_valid), 32'd0);

        // Column 1 / row 2 -> code 6; scan resumes at column 2 after release.
        exp_q.push_back(4'h6);
        press_hold(1, 2, 12);
        n = 0;
        while (col_out == 4'b1101 && n < 40) begin @(negedge clk); n++; end
        check("resume_col2", 32'(col_out), 32'b1011);
        check("held_valid", 32'(key_valid), 32'd1);
        pop_one();
        repeat (2) @(negedge clk);
        check("after_pop_valid", 32'(key_valid), 32'd0);

        // Two-cycle glitch on row 3 in column 3: no push, scan moves on to column 0.
        wait_col_start(3);
        @(negedge clk);
        glitch_rows = 4'b0111;
        glitch_en   = 1'b1;
        repeat (2) @(negedge clk);
        glitch_en   = 1'b0;
        n = 0;
        while (col_out == 4'b0111 && n < 40) begin @(negedge clk); n++; end
        check("glitch_next_col", 32'(col_out), 32'b1110);
        repeat (10) @(negedge clk);
        check("glitch_no_push", 32'(key_valid), 32'd0);

        // Five distinct presses with no reads: first four kept, fifth dropped.
        start = int'($urandom_range(0, 15));
        for (int i = 0; i < 5; i++) begin
            code = 4'((start + i * 3) % 16);
            if (exp_q.size() < 4) exp_q.push_back(code);
            else exp_ovf = 1'b1;
            press_hold(int'(code) / 4, int'(code) % 4, 12);
            repeat (12) @(negedge clk);
        end
        check("ovf_flag", 32'(overflow), 32'(exp_ovf));
        check("ovf_valid", 32'(key_valid), 32'd1);
        drain();
        check("ovf_drained", 32'(key_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'(exp_ovf));

        // Reset in HOLD discards the key; the still-held key is detected again once.
        c = int'($urandom_range(0, 3));
        r = int'($urandom_range(0, 3));
        code = 4'(c * 4 + r);
        wait_col_start(c);
        press_mask[c*4+r] = 1'b1;
        repeat (9) @(negedge clk);
        check("pre_rst_valid", 32'(key_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_col_out", 32'(col_out), 32'hE);
        check("mid_rst_key_valid", 32'(key_valid), 32'd0);
        check("mid_rst_key_code", 32'(key_code), 32'h0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(code);
        wait_valid("redetect_valid");
        press_mask = '0;
        repeat (12) @(negedge clk);
        drain();
        check("redetect_single", 32'(key_valid), 32'd0);

        // Hold code F for 65 cycles past the first push.
        for (int i = 0; i < 1 + EXTRA_REPEATS; i++) exp_q.push_back(4'hF);
        wait_col_start(3);
        press_mask[15] = 1'b1;
        wait_valid("hold_f_valid");
        repeat (65) @(negedge clk);
        press_mask = '0;
        repeat (15) @(negedge clk);
        check("hold_f_overflow", 32'(overflow), 32'd0);
        drain();
        check("hold_f_count", 32'(key_valid), 32'd0);

        // Random presses with random reads in between.
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() > 0 && ($urandom % 2) == 1) pop_one();
            c = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 3));
            code = 4'(c * 4 + r);
            if (exp_q.size() < 4) exp_q.push_back(code);
            else exp_ovf = 1'b1;
            press_hold(c, r, 12);
            repeat (12) @(negedge clk);
        end
        check("rand_overflow", 32'(overflow), 32'(exp_ovf));
        check("rand_valid", 32'(key_valid), 32'(exp_q.size() != 0));
        drain();
        check("rand_drained", 32'(key_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles each column is driven (min 2).
REQ-002 SHALL have parameter DEB_CYCLES, default 500, consecutive stable cycles required for press or release (min 1).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 50000, auto-repeat interval (used only with KEYPAD_REPEAT_EN).
REQ-004 SHALL have port clk  input  1  single system clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port row_in  input  4  keypad rows, active-low, asynchronous to clk.
REQ-007 SHALL have port col_out  output  4  column drive, active-low one-hot: 1110, 1101, 1011, 0111.
REQ-008 SHALL have port key_code  output  4  FIFO head code = col_idx*4 + row_idx.
REQ-009 SHALL have port key_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port key_rd  input  1  pop strobe; ignored when key_valid=0.
REQ-011 SHALL have port overflow  output  1  sticky, set when a key is dropped.

Function
REQ-012 SHALL pass row_in through a 2-FF synchronizer (reset value 4'b1111); all decisions use the synchronized value rs.
REQ-013 SHALL implement FSM states SCAN, PRESS_DEB, HOLD, REL_DEB.
REQ-014 SCAN: SHALL drive col_idx for SCAN_DIV cycles, sample rs on the last dwell cycle; rs==1111 -> next column (3 wraps to 0), else latch row_idx and go to PRESS_DEB.
REQ-015 Row priority: multiple low rows -> lowest index wins.
REQ-016 PRESS_DEB: col_out SHALL be held; rs bit row_idx low for DEB_CYCLES consecutive cycles -> push code, go HOLD; bit high on any cycle -> SCAN, advancing to next column.
REQ-017 HOLD: SHALL stay while bit row_idx is low; when high -> REL_DEB.
REQ-018 REL_DEB: bit row_idx high for DEB_CYCLES consecutive cycles -> SCAN at next column; low on any cycle -> HOLD, no new push.
REQ-019 SHALL buffer codes in a 4-entry FIFO; key_code/key_valid reflect the head combinationally from registers.
REQ-020 Pop: key_rd && key_valid SHALL remove the head at that clk edge.
REQ-021 Push when full without pop SHALL drop the code and set overflow; push and pop in the same cycle when full SHALL succeed with no overflow.
REQ-022 Push and pop same cycle when empty is impossible (key_valid=0); count changes by exactly push-pop otherwise.
REQ-023 Latency: push occurs at most 2 + DEB_CYCLES + 1 cycles after rs bit first samples low during dwell; key_valid rises the cycle after push.

Reset
REQ-024 rst SHALL immediately force: state SCAN, col_idx 0, col_out 4'b1110, FIFO empty, key_valid 0, key_code 4'h0, overflow 0, all counters 0.
REQ-025 rst asserted mid-debounce or mid-hold SHALL discard the pending key; a key still held after release of rst is re-detected through PRESS_DEB.

Configuration
REQ-026 Macro KEYPAD_REPEAT_EN SHALL enable auto-repeat: in HOLD, every REPEAT_CYCLES consecutive cycles the held code is pushed again (counter restarts on each push, clears on leaving HOLD).
REQ-027 Without KEYPAD_REPEAT_EN, exactly one push per press; repeat counter and REPEAT_CYCLES logic SHALL be absent.

Verification (SCAN_DIV=4, DEB_CYCLES=3, REPEAT_CYCLES=20)
REQ-028 Idle rows 1111 for 32 cycles -> col_out cycles 1110,1101,1011,0111 every 4 cycles, wraps; key_valid stays 0.
REQ-029 Hold row_in=1011 while col_out=1101 -> single push key_code=4'h6, key_valid=1 until key_rd; after release, scan resumes at col 2.
REQ-030 Glitch row_in=0111 for 2 cycles in col 3 -> no push, scan advances to col 0.
REQ-031 Five distinct presses with key_rd=0 -> 4 codes retained in order, overflow=1; pops return the first 4 codes in order.
REQ-032 rst pulsed during HOLD -> all outputs reset values immediately; key still held -> re-pushed once after debounce.
REQ-033 With KEYPAD_REPEAT_EN, hold code 4'hF for 65 cycles past first push -> 3 additional pushes; without macro -> 1 push total.
